// File: rtl/lsu_byte_seq_pkg.sv
// Shared definitions for the byte-serial load/store sequencer: access type
// codes (same numbering as the data memory's DMType), FSM states and the
// beat-count helper.
package lsu_pkg;

    // Access type encodings, kept identical to the data memory's DMType codes.
    typedef enum logic [2:0] {
        DM_W  = 3'b000,
        DM_H  = 3'b001,
        DM_HU = 3'b010,
        DM_B  = 3'b011,
        DM_BU = 3'b100
    } dm_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Number of byte beats needed for an access of the given type.
    function automatic logic [2:0] beats_for_type(input logic [2:0] t);
        case (t)
            DM_W:        return 3'd4;
            DM_H, DM_HU: return 3'd2;
            default:     return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_seq_if.sv
// Request/response handshake plus the byte-wide data-memory port.
// master: the core and the memory together; slave: the sequencer.
interface lsu_byte_seq_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_type;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_type, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_type, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_byte_seq_load_extend.sv
// Combinational load-data formatter: picks the little-endian byte lanes that
// belong to the access type and sign- or zero-extends them to 32 bits.
module load_extend
    import lsu_pkg::*;
(
    input  logic [3:0][7:0] bytes_i,
    input  logic [2:0]      type_i,
    output logic [31:0]     data_o
);

    // Select and extend the assembled bytes according to the access type.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for unlisted type codes.
        data_o = 32'h0;
        case (type_i)
            DM_W:    data_o = bytes_i;
            DM_H:    data_o = {{16{bytes_i[1][7]}}, bytes_i[1], bytes_i[0]};
            DM_HU:   data_o = {16'h0, bytes_i[1], bytes_i[0]};
            DM_B:    data_o = {{24{bytes_i[0][7]}}, bytes_i[0]};
            DM_BU:   data_o = {24'h0, bytes_i[0]};
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer: accepts one word/half/byte request, issues it as
// little-endian byte beats on a byte-wide memory port, then returns a
// single-cycle response carrying the extended load data or an error flag.
module lsu_byte_seq
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    lsu_byte_seq_if.slave bus
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [2:0]        type_q;
    logic [1:0]        idx_q;
    logic [3:0][7:0]   bytes_q;

    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic              req_illegal;
    logic [1:0]        idx_d;
    logic [1:0]        last_idx;
    logic [3:0][7:0]   bytes_d;
    logic [31:0]       ext_data;

    // Only the low ADDR_W address bits reach the memory.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

    // Classify the incoming request: bad type code, store of an unsigned
    // type, or (when alignment is enforced) a misaligned word/half.
    always_comb begin
        req_illegal = 1'b0;
        if (bus.req_type > DM_BU) begin
            req_illegal = 1'b1;
        end
        if (bus.req_we && (bus.req_type == DM_HU || bus.req_type == DM_BU)) begin
            req_illegal = 1'b1;
        end
        if (CHECK_ALIGN && bus.req_type == DM_W && bus.req_addr[1:0] != 2'b00) begin
            req_illegal = 1'b1;
        end
        if (CHECK_ALIGN && (bus.req_type == DM_H || bus.req_type == DM_HU)
            && bus.req_addr[0]) begin
            req_illegal = 1'b1;
        end
    end

    // Beat bookkeeping and the byte image including the byte arriving now,
    // so the final beat's data can be extended in the same cycle.
    always_comb begin
        idx_d            = idx_q + 2'd1;
        last_idx         = 2'(beats_for_type(type_q) - 3'd1);
        bytes_d          = bytes_q;
        bytes_d[idx_q]   = bus.mem_rdata;
    end

    load_extend u_load_extend (
        .bytes_i (bytes_d),
        .type_i  (type_q),
        .data_o  (ext_data)
    );

    // Sequencer FSM with registered handshake and memory-port outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: only control state and outputs are reset; the latched
            // request fields and byte lanes are always written before use.
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        wdata_q <= bus.req_wdata;
                        type_q  <= bus.req_type;
                        idx_q   <= 2'd0;
                        if (req_illegal) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q     <= XFER;
                            mem_we_q    <= bus.req_we;
                            mem_addr_q  <= bus.req_addr[ADDR_W-1:0];
                            mem_wdata_q <= bus.req_we ? bus.req_wdata[7:0] : 8'h0;
                        end
                    end
                end

                XFER: begin
                    bytes_q[idx_q] <= bus.mem_rdata;
                    if (idx_q == last_idx) begin
                        state_q      <= RESP;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= 8'h0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? 32'h0 : ext_data;
                    end else begin
                        idx_q       <= idx_d;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                        mem_wdata_q <= we_q ? wdata_q[{idx_d, 3'b000} +: 8] : 8'h0;
                    end
                end

                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end

                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= 8'h0;
                end
            endcase
        end
    end

    // Reset wins within its own cycle: an in-flight store beat is suppressed
    // immediately rather than one cycle later.
    assign bus.mem_we     = mem_we_q & ~rst;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Self-checking bench for lsu_byte_seq. Two instances run side by side, one
// enforcing alignment and one not. Each has a byte-array memory and a
// transaction-level model that predicts, cycle by cycle, the handshake, the
// memory beats and the response from the access rules.
module tb_lsu_byte_seq;

    localparam int AW = 6;
    localparam int MSZ = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int gcyc = 0;

    logic [1:0]  rst_v = 2'b11;
    logic [1:0]  rv_v  = 2'b00;
    logic [1:0]  we_v  = 2'b00;
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [2:0]  type_v  [2];

    logic [1:0]  ready_w;
    logic [1:0]  resp_v_w;
    logic [1:0]  resp_e_w;
    logic [31:0] resp_d_w [2];

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, gcyc);
        end
    endtask

    function automatic bit illegal_req(input bit we, input logic [31:0] a,
                                       input logic [2:0] t, input bit align);
        if (t > 3'd4) return 1'b1;
        if (we && (t == 3'd2 || t == 3'd4)) return 1'b1;
        if (align && t == 3'd0 && (a % 4) != 0) return 1'b1;
        if (align && (t == 3'd1 || t == 3'd2) && (a % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int nbeats(input logic [2:0] t);
        if (t == 3'd0) return 4;
        if (t <= 3'd2) return 2;
        return 1;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        return 8'(w >> (8 * k));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        lsu_byte_seq_if #(.ADDR_W(AW)) bus ();
        logic [7:0] mem     [MSZ];
        logic [7:0] ref_mem [MSZ];

        assign bus.req_valid = rv_v[g];
        assign bus.req_we    = we_v[g];
        assign bus.req_addr  = addr_v[g];
        assign bus.req_wdata = wdata_v[g];
        assign bus.req_type  = type_v[g];
        assign bus.mem_rdata = mem[bus.mem_addr];

        assign ready_w[g]  = bus.req_ready;
        assign resp_v_w[g] = bus.resp_valid;
        assign resp_e_w[g] = bus.resp_err;
        assign resp_d_w[g] = bus.resp_rdata;

        lsu_byte_seq #(.ADDR_W(AW), .CHECK_ALIGN(g == 0)) dut (
            .clk (clk),
            .rst (rst_v[g]),
            .bus (bus)
        );

        initial begin
            for (int i = 0; i < MSZ; i++) begin
                logic [7:0] v;
                v = 8'($urandom);
                mem[i] <= v;
                ref_mem[i] = v;
            end
        end

        always @(posedge clk) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        end

        // Little-endian load result from the model memory.
        function automatic logic [31:0] expect_load(input int a, input logic [2:0] t);
            int b0, b1, v;
            b0 = int'(ref_mem[a % MSZ]);
            b1 = int'(ref_mem[(a + 1) % MSZ]);
            case (t)
                3'd0: return {ref_mem[(a + 3) % MSZ], ref_mem[(a + 2) % MSZ],
                              ref_mem[(a + 1) % MSZ], ref_mem[a % MSZ]};
                3'd1: begin
                    v = b1 * 256 + b0;
                    if (v >= 32768) v = v - 65536;
                    return 32'(v);
                end
                3'd2: return 32'(b1 * 256 + b0);
                3'd3: begin
                    v = b0;
                    if (v >= 128) v = v - 256;
                    return 32'(v);
                end
                default: return 32'(b0);
            endcase
        endfunction

        // Model of one in-flight transaction: handshake cycle p_t, p_n beats
        // in cycles p_t+1..p_t+p_n, response in cycle p_t+p_n+1.
        int          cyc = 0;
        int          ready_cyc = 0;
        bit          p_act = 1'b0;
        bit          p_we = 1'b0;
        bit          p_err = 1'b0;
        int          p_t = 0;
        int          p_n = 0;
        int          p_addr = 0;
        logic [31:0] p_wdata = 32'h0;
        logic [31:0] p_rdata = 32'h0;

        always @(posedge clk) begin
            if (rst_v[g]) begin
                p_act     <= 1'b0;
                ready_cyc <= cyc + 1;
            end else begin
                if (p_act && p_we && !p_err && cyc > p_t && cyc <= p_t + p_n)
                    ref_mem[(p_addr + cyc - p_t - 1) % MSZ] <= byte_of(p_wdata, cyc - p_t - 1);
                if (rv_v[g] && cyc >= ready_cyc) begin
                    bit bad;
                    int n;
                    int a;
                    bad = illegal_req(we_v[g], addr_v[g], type_v[g], (g == 0));
                    n   = bad ? 0 : nbeats(type_v[g]);
                    a   = int'(addr_v[g] % MSZ);
                    p_act     <= 1'b1;
                    p_t       <= cyc;
                    p_n       <= n;
                    p_we      <= we_v[g];
                    p_err     <= bad;
                    p_addr    <= a;
                    p_wdata   <= wdata_v[g];
                    p_rdata   <= (bad || we_v[g]) ? 32'h0 : expect_load(a, type_v[g]);
                    ready_cyc <= cyc + n + 2;
                end else if (p_act && cyc >= p_t + p_n + 1) begin
                    p_act <= 1'b0;
                end
            end
            cyc <= cyc + 1;
        end

        always @(negedge clk) begin
            if (chk_en) begin
                int  k;
                bit  beat;
                bit  resp;
                k    = cyc - p_t - 1;
                beat = p_act && !p_err && cyc > p_t && cyc <= p_t + p_n;
                resp = p_act && cyc == p_t + p_n + 1;
                check("req_ready", 32'(bus.req_ready), 32'(cyc >= ready_cyc));
                check("mem_we", 32'(bus.mem_we), 32'(beat && p_we && !rst_v[g]));
                check("mem_addr", 32'(bus.mem_addr), beat ? 32'((p_addr + k) % MSZ) : 32'h0);
                if (!beat || p_we)
                    check("mem_wdata", 32'(bus.mem_wdata), beat ? 32'(byte_of(p_wdata, k)) : 32'h0);
                check("resp_valid", 32'(bus.resp_valid), 32'(resp));
                check("resp_rdata", bus.resp_rdata, resp ? p_rdata : 32'h0);
                check("resp_err", 32'(bus.resp_err), 32'(resp && p_err));
            end
        end
    end

    // Present a request, hold it until accepted, optionally wait for the
    // response. Entered and left #1 after a rising edge.
    task automatic issue(input int ln, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] typ,
                         input bit wait_resp, output int acc, output int lat,
                         output logic [31:0] rdata, output bit err);
        acc   = -1;
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        rv_v[ln]    = 1'b1;
        we_v[ln]    = we;
        addr_v[ln]  = addr;
        wdata_v[ln] = wdata;
        type_v[ln]  = typ;
        for (int k = 0; k < 40 && acc < 0; k++) begin
            @(negedge clk);
            if (ready_w[ln]) acc = gcyc;
            @(posedge clk);
            #1;
        end
        rv_v[ln] = 1'b0;
        check("accepted", 32'(acc >= 0), 32'h1);
        if (wait_resp && acc >= 0) begin
            for (int k = 1; k <= 20 && lat < 0; k++) begin
                @(negedge clk);
                if (resp_v_w[ln]) begin
                    lat   = k;
                    rdata = resp_d_w[ln];
                    err   = resp_e_w[ln];
                end
                @(posedge clk);
                #1;
            end
            check("resp_seen", 32'(lat >= 0), 32'h1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_phase(input int ln, input int count);
        for (int r = 0; r < count; r++) begin
            bit          we;
            logic [2:0]  typ;
            logic [31:0] addr;
            logic [31:0] wdata;
            int          acc, lat;
            logic [31:0] rd;
            bit          er;
            we    = 1'($urandom_range(0, 1));
            typ   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) typ = 3'($urandom_range(0, 4));
            addr  = $urandom;
            if ($urandom_range(0, 1) != 0) addr[1:0] = 2'b00;
            wdata = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                issue(ln, we, addr, wdata, typ, 1'b0, acc, lat, rd, er);
                idle($urandom_range(0, 4));
                rst_v[ln] = 1'b1;
                idle(1);
                rst_v[ln] = 1'b0;
            end else begin
                issue(ln, we, addr, wdata, typ, 1'b1, acc, lat, rd, er);
            end
            idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end (cycle %0d)", gcyc);
        $fatal(1);
    end

    initial begin
        int          acc, acc2, lat;
        logic [31:0] rd;
        bit          er;
        logic [7:0]  old14, old15;

        for (int i = 0; i < 2; i++) begin
            addr_v[i]  = 32'h0;
            wdata_v[i] = 32'h0;
            type_v[i]  = 3'h0;
        end
        idle(3);
        rst_v  = 2'b00;
        chk_en = 1'b1;
        idle(1);

        // Aligned instance: word store then loads of it.
        issue(0, 1'b1, 32'd4, 32'h8765_4321, 3'd0, 1'b1, acc, lat, rd, er);
        check("st_w lat", 32'(lat), 32'd5);
        check("st_w err", 32'(er), 32'h0);
        check("st_w rdata", rd, 32'h0);
        check("st_w bytes", {lane[0].mem[7], lane[0].mem[6], lane[0].mem[5], lane[0].mem[4]},
              32'h8765_4321);

        issue(0, 1'b0, 32'd6, 32'h0, 3'd1, 1'b1, acc, lat, rd, er);
        check("ld_h rdata", rd, 32'hFFFF_8765);
        check("ld_h lat", 32'(lat), 32'd3);
        issue(0, 1'b0, 32'd6, 32'h0, 3'd2, 1'b1, acc, lat, rd, er);
        check("ld_hu rdata", rd, 32'h0000_8765);
        issue(0, 1'b0, 32'd7, 32'h0, 3'd3, 1'b1, acc, lat, rd, er);
        check("ld_b rdata", rd, 32'hFFFF_FF87);
        issue(0, 1'b0, 32'd7, 32'h0, 3'd4, 1'b1, acc, lat, rd, er);
        check("ld_bu rdata", rd, 32'h0000_0087);
        issue(0, 1'b0, 32'd4, 32'h0, 3'd3, 1'b1, acc, lat, rd, er);
        check("ld_b4 rdata", rd, 32'h0000_0021);
        check("ld_b4 lat", 32'(lat), 32'd2);

        // Error responses.
        issue(0, 1'b0, 32'd5, 32'h0, 3'd0, 1'b1, acc, lat, rd, er);
        check("misal_w err", 32'(er), 32'h1);
        check("misal_w lat", 32'(lat), 32'd1);
        check("misal_w rdata", rd, 32'h0);
        issue(0, 1'b1, 32'd0, 32'hDEAD_BEEF, 3'd4, 1'b1, acc, lat, rd, er);
        check("st_bu err", 32'(er), 32'h1);
        issue(0, 1'b0, 32'd0, 32'h0, 3'd7, 1'b1, acc, lat, rd, er);
        check("type7 err", 32'(er), 32'h1);

        // Back-to-back: second request held while busy, accepted on ready.
        issue(0, 1'b1, 32'd8, 32'h0F1E_2D3C, 3'd0, 1'b0, acc, lat, rd, er);
        issue(0, 1'b0, 32'd8, 32'h0, 3'd0, 1'b1, acc2, lat, rd, er);
        check("b2b accept gap", 32'(acc2 - acc), 32'd6);
        check("b2b rdata", rd, 32'h0F1E_2D3C);
        idle(1);

        // Reset during beat 2 of a word store.
        old14 = lane[0].mem[14];
        old15 = lane[0].mem[15];
        issue(0, 1'b1, 32'd12, 32'h1122_3344, 3'd0, 1'b0, acc, lat, rd, er);
        idle(2);
        rst_v[0] = 1'b1;
        idle(1);
        rst_v[0] = 1'b0;
        @(negedge clk);
        check("rst ready", 32'(ready_w[0]), 32'h1);
        check("rst resp_valid", 32'(resp_v_w[0]), 32'h0);
        check("rst bytes", {lane[0].mem[15], lane[0].mem[14], lane[0].mem[13], lane[0].mem[12]},
              {old15, old14, 8'h33, 8'h44});
        @(posedge clk);
        #1;

        // Unaligned instance: wrap-around word and a misaligned half.
        issue(1, 1'b1, 32'd62, 32'hAABB_CCDD, 3'd0, 1'b1, acc, lat, rd, er);
        check("wrap st lat", 32'(lat), 32'd5);
        check("wrap bytes", {lane[1].mem[1], lane[1].mem[0], lane[1].mem[63], lane[1].mem[62]},
              32'hAABB_CCDD);
        issue(1, 1'b0, 32'd62, 32'h0, 3'd0, 1'b1, acc, lat, rd, er);
        check("wrap ld rdata", rd, 32'hAABB_CCDD);
        issue(1, 1'b0, 32'd63, 32'h0, 3'd1, 1'b1, acc, lat, rd, er);
        check("misal_h rdata", rd, 32'hFFFF_BBCC);
        check("misal_h err", 32'(er), 32'h0);
        check("misal_h lat", 32'(lat), 32'd3);

        rand_phase(0, 150);
        rand_phase(1, 150);
        idle(4);

        for (int i = 0; i < MSZ; i++) begin
            check("final mem0", 32'(lane[0].mem[i]), 32'(lane[0].ref_mem[i]));
            check("final mem1", 32'(lane[1].mem[i]), 32'(lane[1].ref_mem[i]));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
